reg_bus_arbiter: RTL

- Shares the single register-bus port of the datapath block (cmd_valid/op/addr/wr_data/rd_data) between NUM_REQ independent requesters, e.g. a config sequencer and a debug/backdoor master.
- Round-robin arbitration with a one-command-at-a-time FSM.
- Absorbs the downstream 1-cycle registered read latency and returns read data to the owning requester only.
- Sits directly in front of the datapath's bus port; the datapath is unmodified.

---
 rtl/reg_bus_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register-bus port among NUM_REQ requesters.
// Round-robin arbitration; one command in flight at a time (IDLE/CMD/RDWAIT).
// The 1-cycle registered read latency of the downstream port is absorbed, and
// read data is returned only to the requester that issued the read.
// Optional build macro REG_BUS_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins) instead of round-robin. FSM, timing and handshake are unchanged.
module reg_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      bus_cmd_valid,
  output logic                      bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wr_data,
  input  logic [DATA_W-1:0]         bus_rd_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       last_q, last_d;
  logic [PW-1:0]       own_q, own_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                busy_q, busy_d;
  logic                bus_cmd_valid_q, bus_cmd_valid_d;
  logic                bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;

  logic                any_req;
  logic [PW-1:0]       win;

  // Winner select: first requester after the last grant, or lowest index.
  always_comb begin
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    any_req = |req;
    win     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) win = PW'(i);
`else
    int   idx;
    logic found;
    any_req = |req;
    win     = '0;
    idx     = 0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PW-1:0]]) begin
        win   = idx[PW-1:0];
        found = 1'b1;
      end
    end
`endif
  end

  // Next-state and registered-output logic; bus addr/data and rdata hold.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    own_d           = own_q;
    gnt_d           = '0;
    rsp_valid_d     = '0;
    rsp_rdata_d     = rsp_rdata_q;
    bus_cmd_valid_d = 1'b0;
    bus_op_d        = 1'b0;
    bus_addr_d      = bus_addr_q;
    bus_wr_data_d   = bus_wr_data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d         = CMD;
          bus_cmd_valid_d = 1'b1;
          bus_op_d        = req_op[win];
          bus_addr_d      = req_addr[int'(win)*ADDR_W +: ADDR_W];
          bus_wr_data_d   = req_wdata[int'(win)*DATA_W +: DATA_W];
          gnt_d[win]      = 1'b1;
          last_d          = win;
          own_d           = win;
        end
      end
      // req is deliberately not sampled here so a held req cannot double-issue
      CMD:     state_d = bus_op_q ? IDLE : RDWAIT;
      RDWAIT: begin
        rsp_rdata_d        = bus_rd_data;
        rsp_valid_d[own_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_q          <= PW'(NUM_REQ - 1);
      own_q           <= '0;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      busy_q          <= 1'b0;
      bus_cmd_valid_q <= 1'b0;
      bus_op_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wr_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      own_q           <= own_d;
      gnt_q           <= gnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      busy_q          <= busy_d;
      bus_cmd_valid_q <= bus_cmd_valid_d;
      bus_op_q        <= bus_op_d;
      bus_addr_q      <= bus_addr_d;
      bus_wr_data_q   <= bus_wr_data_d;
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;
  assign bus_cmd_valid = bus_cmd_valid_q;
  assign bus_op        = bus_op_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr_data   = bus_wr_data_q;

endmodule
